// File: rtl/core_config.sv
// Core sizing constants shared by the rename-stage free list and its users.
package core_config;

   localparam int unsigned PHYREG       = 64;
   localparam int unsigned ARCHREG      = 32;
   localparam int unsigned RENAME_WIDTH = 2;
   localparam int unsigned COMMIT_WIDTH = 2;
   localparam int unsigned FL_DEPTH     = PHYREG - ARCHREG;
   localparam int unsigned FL_PTR_W     = $clog2(FL_DEPTH) + 1;

endpackage

// File: rtl/core_types.sv
// Shared physical-register and free-list pointer types.
package core_types;

   import core_config::*;

   typedef logic [$clog2(PHYREG)-1:0] preg_t;
   typedef logic [FL_PTR_W-1:0]       fl_ptr_t;

endpackage

// File: rtl/lane_prefix_count.sv
// Per-lane exclusive prefix popcount and total popcount of a request vector.
module lane_prefix_count #(
   parameter  int unsigned WIDTH = 2,
   localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0]         vec,
   output logic [WIDTH-1:0][CW-1:0] prefix,
   output logic [CW-1:0]            total
);

   always_comb begin
      logic [CW-1:0] acc;
      acc    = '0;
      prefix = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         prefix[i] = acc;
         acc       = acc + CW'(vec[i]);
      end
      total = acc;
   end

endmodule

// File: rtl/prf_free_list_ckpt.sv
// Circular preg free list with compacted multi-lane alloc/reclaim and one-cycle flush recovery.
// Define FREE_LIST_PERF_EN to add stall-cycle and low-water-mark performance outputs.
module prf_free_list_ckpt #(
   parameter  int unsigned PHYREG       = core_config::PHYREG,
   parameter  int unsigned ARCHREG      = core_config::ARCHREG,
   parameter  int unsigned RENAME_WIDTH = core_config::RENAME_WIDTH,
   parameter  int unsigned COMMIT_WIDTH = core_config::COMMIT_WIDTH,
   localparam int unsigned PREG_W       = $clog2(PHYREG),
   localparam int unsigned DEPTH        = PHYREG - ARCHREG,
   localparam int unsigned IDX_W        = $clog2(DEPTH),
   localparam int unsigned PTR_W        = IDX_W + 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [RENAME_WIDTH-1:0]        rename_req,
   output logic [RENAME_WIDTH*PREG_W-1:0] rename_preg,
   output logic                           stallreq_o,
   input  logic [COMMIT_WIDTH-1:0]        commit_valid,
   input  logic [COMMIT_WIDTH*PREG_W-1:0] commit_old_preg,
   input  logic                           flush,
   output logic [PTR_W-1:0]               free_cnt_o
`ifdef FREE_LIST_PERF_EN
   ,
   output logic [31:0]                    perf_stall_cycles_o,
   output logic [PTR_W-1:0]               perf_min_free_o
`endif
);

   localparam int unsigned RCW = $clog2(RENAME_WIDTH + 1);
   localparam int unsigned CCW = $clog2(COMMIT_WIDTH + 1);

   logic [RENAME_WIDTH-1:0][RCW-1:0] rpre;
   logic [RCW-1:0]                   rnum;
   logic [COMMIT_WIDTH-1:0][CCW-1:0] cpre;
   logic [CCW-1:0]                   cnum;

   logic [PREG_W-1:0] queue_q [DEPTH];
   logic [PTR_W-1:0]  spec_head_q, spec_head_d;
   logic [PTR_W-1:0]  arch_head_q, arch_head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [PTR_W-1:0]  free_cnt_q, free_cnt_d;
   logic [PTR_W-1:0]  spec_cnt;
   logic [IDX_W-1:0]  ridx [RENAME_WIDTH];
   logic [IDX_W-1:0]  cidx [COMMIT_WIDTH];

   lane_prefix_count #(.WIDTH(RENAME_WIDTH)) u_rename_cnt (
      .vec    (rename_req),
      .prefix (rpre),
      .total  (rnum)
   );

   lane_prefix_count #(.WIDTH(COMMIT_WIDTH)) u_commit_cnt (
      .vec    (commit_valid),
      .prefix (cpre),
      .total  (cnum)
   );

   always_comb begin
      spec_cnt    = tail_q - spec_head_q;
      stallreq_o  = !flush && (PTR_W'(rnum) > spec_cnt);
      rename_preg = '0;
      for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
         ridx[i] = spec_head_q[IDX_W-1:0] + IDX_W'(rpre[i]);
         if (rename_req[i]) begin
            rename_preg[i*PREG_W +: PREG_W] = queue_q[ridx[i]];
         end
      end
      for (int unsigned j = 0; j < COMMIT_WIDTH; j++) begin
         cidx[j] = tail_q[IDX_W-1:0] + IDX_W'(cpre[j]);
      end
   end

   always_comb begin
      tail_d      = tail_q + PTR_W'(cnum);
      arch_head_d = arch_head_q + PTR_W'(cnum);
      spec_head_d = spec_head_q;
      // Flush rewinds to the post-commit architectural head, discarding this cycle's renames.
      if (flush) begin
         spec_head_d = arch_head_d;
      end else if (!stallreq_o) begin
         spec_head_d = spec_head_q + PTR_W'(rnum);
      end
      free_cnt_d = tail_d - spec_head_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            queue_q[k] <= PREG_W'(ARCHREG + k);
         end
         spec_head_q <= '0;
         arch_head_q <= '0;
         tail_q      <= PTR_W'(DEPTH);
         free_cnt_q  <= PTR_W'(DEPTH);
      end else begin
         for (int unsigned j = 0; j < COMMIT_WIDTH; j++) begin
            if (commit_valid[j]) begin
               queue_q[cidx[j]] <= commit_old_preg[j*PREG_W +: PREG_W];
            end
         end
         spec_head_q <= spec_head_d;
         arch_head_q <= arch_head_d;
         tail_q      <= tail_d;
         free_cnt_q  <= free_cnt_d;
      end
   end

   assign free_cnt_o = free_cnt_q;

`ifdef FREE_LIST_PERF_EN
   logic [31:0]      stall_cyc_q;
   logic [PTR_W-1:0] min_free_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cyc_q <= '0;
         min_free_q  <= PTR_W'(DEPTH);
      end else begin
         if (stallreq_o && (rnum != '0) && (stall_cyc_q != '1)) begin
            stall_cyc_q <= stall_cyc_q + 32'd1;
         end
         if (free_cnt_d < min_free_q) begin
            min_free_q <= free_cnt_d;
         end
      end
   end

   assign perf_stall_cycles_o = stall_cyc_q;
   assign perf_min_free_o     = min_free_q;
`endif

endmodule

// File: tb/tb_prf_free_list_ckpt.sv
// Self-checking bench: directed vector table, corner sequences, and random traffic vs a queue model.
module tb_prf_free_list_ckpt;

   import core_config::*;
   import core_types::*;

   localparam int PW    = $clog2(PHYREG);
   localparam int DEPTH = FL_DEPTH;

   logic                           clk = 1'b0;
   logic                           rst_n;
   logic [RENAME_WIDTH-1:0]        rename_req;
   logic [RENAME_WIDTH*PW-1:0]     rename_preg;
   logic                           stallreq_o;
   logic [COMMIT_WIDTH-1:0]        commit_valid;
   logic [COMMIT_WIDTH*PW-1:0]     commit_old_preg;
   logic                           flush;
   fl_ptr_t                        free_cnt_o;
`ifdef FREE_LIST_PERF_EN
   logic [31:0]                    perf_stall_cycles_o;
   fl_ptr_t                        perf_min_free_o;
`endif

   prf_free_list_ckpt dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rename_req      (rename_req),
      .rename_preg     (rename_preg),
      .stallreq_o      (stallreq_o),
      .commit_valid    (commit_valid),
      .commit_old_preg (commit_old_preg),
      .flush           (flush),
      .free_cnt_o      (free_cnt_o)
`ifdef FREE_LIST_PERF_EN
      ,
      .perf_stall_cycles_o (perf_stall_cycles_o),
      .perf_min_free_o     (perf_min_free_o)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: free pregs in arch order; the first spec_taken are speculatively handed out.
   int fq [$];
   int spec_taken;

   logic  s_stall;
   preg_t s_p [RENAME_WIDTH];
   int    s_cnt;

   typedef struct {
      logic       rst;
      logic [1:0] rr;
      logic [1:0] cv;
      preg_t      o0;
      preg_t      o1;
      logic       fl;
      logic       chk;
      logic       stall;
      preg_t      p0;
      preg_t      p1;
      int         cnt;
   } vec_t;

   vec_t tbl [9];

   function automatic vec_t mk(input logic rst, input logic [1:0] rr, input logic [1:0] cv,
                               input preg_t o0, input preg_t o1, input logic fl, input logic chk,
                               input logic stall, input preg_t p0, input preg_t p1, input int cnt);
      vec_t v;
      v.rst = rst; v.rr = rr; v.cv = cv; v.o0 = o0; v.o1 = o1; v.fl = fl;
      v.chk = chk; v.stall = stall; v.p0 = p0; v.p1 = p1; v.cnt = cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      fq = {};
      for (int k = 0; k < DEPTH; k++) fq.push_back(ARCHREG + k);
      spec_taken = 0;
   endtask

   function automatic bit in_fq(input int p);
      foreach (fq[k]) if (fq[k] == p) return 1'b1;
      return 1'b0;
   endfunction

   // Drive one cycle's inputs, sample combinational outputs, clock, then sample free_cnt_o.
   task automatic cycle(input logic [1:0] rr, input logic [1:0] cv, input preg_t o0,
                        input preg_t o1, input logic fl);
      rename_req      = rr;
      commit_valid    = cv;
      commit_old_preg = {o1, o0};
      flush           = fl;
      #1;
      s_stall = stallreq_o;
      for (int i = 0; i < RENAME_WIDTH; i++) s_p[i] = rename_preg[i*PW +: PW];
      @(posedge clk);
      #1;
      s_cnt = int'(free_cnt_o);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      rename_req = '0; commit_valid = '0; commit_old_preg = '0; flush = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   initial begin
      //            rst   rr     cv     o0     o1     fl    chk   stall p0     p1     cnt
      tbl[0] = mk(1'b1, 2'b11, 2'b00, 6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 6'd32, 6'd33, 30);
      tbl[1] = mk(1'b1, 2'b10, 2'b00, 6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 6'd0,  6'd32, 31);
      tbl[2] = mk(1'b0, 2'b01, 2'b00, 6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 6'd33, 6'd0,  30);
      tbl[3] = mk(1'b1, 2'b11, 2'b00, 6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 6'd32, 6'd33, 30);
      tbl[4] = mk(1'b0, 2'b11, 2'b00, 6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 6'd34, 6'd35, 28);
      tbl[5] = mk(1'b0, 2'b11, 2'b00, 6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 6'd36, 6'd37, 26);
      tbl[6] = mk(1'b0, 2'b00, 2'b11, 6'd1,  6'd2,  1'b0, 1'b1, 1'b0, 6'd0,  6'd0,  28);
      // Flush with a same-cycle commit: spec_head = arch_head = 3, tail = 35.
      tbl[7] = mk(1'b0, 2'b11, 2'b01, 6'd3,  6'd0,  1'b1, 1'b0, 1'b0, 6'd0,  6'd0,  32);
      tbl[8] = mk(1'b0, 2'b11, 2'b00, 6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 6'd35, 6'd36, 30);

      rst_n = 1'b0;
      rename_req = '0; commit_valid = '0; commit_old_preg = '0; flush = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_free_cnt", 32'(free_cnt_o), DEPTH);
      check("reset_stall", 32'(stallreq_o), 0);
      check("reset_rename_preg", 32'(rename_preg), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int v = 0; v < 9; v++) begin
         if (tbl[v].rst) do_reset();
         cycle(tbl[v].rr, tbl[v].cv, tbl[v].o0, tbl[v].o1, tbl[v].fl);
         check($sformatf("tbl%0d_stall", v), 32'(s_stall), 32'(tbl[v].stall));
         if (tbl[v].chk) begin
            check($sformatf("tbl%0d_lane0", v), 32'(s_p[0]), 32'(tbl[v].p0));
            check($sformatf("tbl%0d_lane1", v), 32'(s_p[1]), 32'(tbl[v].p1));
         end
         check($sformatf("tbl%0d_free_cnt", v), s_cnt, tbl[v].cnt);
      end

      // Drain to one entry, then all-or-nothing stall, last grant, and empty stall.
      do_reset();
      repeat (15) cycle(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
      cycle(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
      check("drain_lane0_62", 32'(s_p[0]), 62);
      check("drain_cnt_1", s_cnt, 1);
      cycle(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
      check("partial_stall", 32'(s_stall), 1);
      check("partial_cnt_kept", s_cnt, 1);
      cycle(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
      check("last_stall", 32'(s_stall), 0);
      check("last_lane0_63", 32'(s_p[0]), 63);
      check("last_cnt_0", s_cnt, 0);
      cycle(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
      check("empty_stall", 32'(s_stall), 1);

      // Reclaim into an empty list: no same-cycle bypass, then wrapped reads in lane order.
      cycle(2'b01, 2'b11, 6'd5, 6'd7, 1'b0);
      check("nobypass_stall", 32'(s_stall), 1);
      check("reclaim_cnt_2", s_cnt, 2);
      cycle(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
      check("wrap_stall", 32'(s_stall), 0);
      check("wrap_lane0", 32'(s_p[0]), 5);
      check("wrap_lane1", 32'(s_p[1]), 7);
      check("wrap_cnt_0", s_cnt, 0);
`ifdef FREE_LIST_PERF_EN
      check("perf_stall_cycles", perf_stall_cycles_o, 3);
      check("perf_min_free", 32'(perf_min_free_o), 0);
`endif

      // Asynchronous reset mid-stream after 20 allocations and 4 frees.
      do_reset();
      repeat (10) cycle(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
      cycle(2'b00, 2'b11, 6'd1, 6'd2, 1'b0);
      cycle(2'b00, 2'b11, 6'd3, 6'd4, 1'b0);
      check("pre_reset_cnt", s_cnt, 16);
      rename_req = '0; commit_valid = '0; flush = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_free_cnt", 32'(free_cnt_o), DEPTH);
      check("async_rst_stall", 32'(stallreq_o), 0);
      check("async_rst_rename", 32'(rename_preg), 0);
      rename_req = 2'b11;
      #1;
      check("async_rst_queue_lane0", 32'(rename_preg[PW-1:0]), 32);
      check("async_rst_queue_lane1", 32'(rename_preg[2*PW-1:PW]), 33);
      rename_req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      cycle(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
      check("post_rst_lane0", 32'(s_p[0]), 32);
      check("post_rst_lane1", 32'(s_p[1]), 33);
      check("post_rst_cnt", s_cnt, 30);

      // Random traffic against the queue model.
      do_reset();
      begin
`ifdef FREE_LIST_PERF_EN
         int m_stalls = 0;
         int m_min    = DEPTH;
`endif
         for (int n = 0; n < 3000; n++) begin
            logic [1:0] rr, cv;
            preg_t      o [2];
            logic       fl, est;
            int         k, rn, pre, cnt0, p;
            fl = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < 2; i++) rr[i] = ($urandom_range(0, 3) != 0);
            k = 0;
            for (int j = 0; j < 2; j++) begin
               cv[j] = (k < spec_taken) && ($urandom_range(0, 1) == 1);
               o[j]  = '0;
               if (cv[j]) begin
                  k++;
                  p = 1;
                  for (int t = 0; t < 1000; t++) begin
                     p = int'($urandom_range(1, PHYREG - 1));
                     if (!in_fq(p) && !(j == 1 && cv[0] && p == int'(o[0]))) break;
                  end
                  o[j] = preg_t'(p);
               end
            end
            rn   = int'(rr[0]) + int'(rr[1]);
            cnt0 = fq.size() - spec_taken;
            est  = !fl && (rn > cnt0);
            cycle(rr, cv, o[0], o[1], fl);
            check("rnd_stall", 32'(s_stall), 32'(est));
            pre = 0;
            for (int i = 0; i < 2; i++) begin
               if (!rr[i]) begin
                  check("rnd_idle_lane", 32'(s_p[i]), 0);
               end else begin
                  if (!fl && !est) check("rnd_lane", 32'(s_p[i]), fq[spec_taken + pre]);
                  pre++;
               end
            end
            repeat (k) void'(fq.pop_front());
            spec_taken -= k;
            for (int j = 0; j < 2; j++) if (cv[j]) fq.push_back(int'(o[j]));
            if (fl) spec_taken = 0;
            else if (!est) spec_taken += rn;
            check("rnd_free_cnt", s_cnt, fq.size() - spec_taken);
            check("rnd_cnt_le_depth", 32'(s_cnt <= DEPTH), 1);
`ifdef FREE_LIST_PERF_EN
            if (est && rn > 0) m_stalls++;
            if (fq.size() - spec_taken < m_min) m_min = fq.size() - spec_taken;
`endif
         end
`ifdef FREE_LIST_PERF_EN
         check("rnd_perf_stalls", perf_stall_cycles_o, m_stalls);
         check("rnd_perf_min", 32'(perf_min_free_o), m_min);
`endif
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
